// File: rtl/draw_pkg.sv
// Shared types for the line-animation scheduler: coordinates, screen size,
// scheduler FSM states and a packed line record.
package draw_pkg;

   typedef logic [10:0] coord_t;

   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;
   localparam int FRAME_CNT_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      ERASE_GO,
      ERASE_WAIT,
      DRAW_GO,
      DRAW_WAIT,
      HOLD,
      STEP
   } sched_state_t;

   typedef struct packed {
      coord_t x0;
      coord_t y0;
      coord_t x1;
      coord_t y1;
   } line_t;

endpackage

// File: rtl/frame_hold_timer.sv
// Counts frame_tick pulses while enabled. done fires combinationally on the
// tick that completes HOLD_FRAMES frames. The counter saturates at its maximum.
module frame_hold_timer
   import draw_pkg::*;
#(
   parameter int HOLD_FRAMES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   input  logic frame_tick,
   output logic done
);

   localparam logic [FRAME_CNT_W:0] HOLD_LIM = (FRAME_CNT_W + 1)'(HOLD_FRAMES);

   logic [FRAME_CNT_W-1:0] count;
   logic                   tick;

   assign tick = enable && frame_tick;

   // NOTE: sequential state is written with <= only, so every register in the
   // design samples pre-edge values and ordering between blocks cannot matter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (tick && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   assign done = tick && (({1'b0, count} + 1'b1) >= HOLD_LIM);

endmodule

// File: rtl/draw_scheduler.sv
// Sequences line_drawer: draw a line, hold it HOLD_FRAMES frames, step the
// animator, optionally erase the old line first (macro DRAW_SCHED_ERASE_EN).
module draw_scheduler
   import draw_pkg::*;
#(
   parameter int HOLD_FRAMES = 2
) (
   input  logic   clk,
   input  logic   reset,
   input  coord_t x0,
   input  coord_t y0,
   input  coord_t x1,
   input  coord_t y1,
   input  logic   frame_tick,
   input  logic   ld_done,
   output logic   ld_start,
   output coord_t ld_x0,
   output coord_t ld_y0,
   output coord_t ld_x1,
   output coord_t ld_y1,
   output logic   ld_color,
   output logic   anim_step,
   output logic   busy
);

   sched_state_t state;
   sched_state_t state_next;
   line_t        ld_line;
   logic         line_done;
   logic         hold_done;

`ifdef DRAW_SCHED_ERASE_EN
   line_t        cur;
   logic         have_prev;
`endif

   // ld_start is registered, so it is high in the first *_WAIT cycle; a done
   // pulse coinciding with it belongs to an earlier command and is ignored.
   assign line_done = ld_done && !ld_start;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: state_next gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:      state_next = DRAW_GO;
         DRAW_GO:   state_next = DRAW_WAIT;
         DRAW_WAIT: if (line_done) state_next = HOLD;
         HOLD:      if (hold_done) state_next = STEP;
`ifdef DRAW_SCHED_ERASE_EN
         STEP:       state_next = have_prev ? ERASE_GO : DRAW_GO;
         ERASE_GO:   state_next = ERASE_WAIT;
         ERASE_WAIT: if (line_done) state_next = DRAW_GO;
`else
         STEP:      state_next = DRAW_GO;
`endif
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ld_start  <= 1'b0;
         ld_color  <= 1'b0;
         ld_line   <= '0;
`ifdef DRAW_SCHED_ERASE_EN
         cur       <= '0;
         have_prev <= 1'b0;
`endif
      end else begin
         ld_start <= 1'b0;
         unique case (state)
            DRAW_GO: begin
               ld_line   <= '{x0: x0, y0: y0, x1: x1, y1: y1};
               ld_color  <= 1'b1;
               ld_start  <= 1'b1;
`ifdef DRAW_SCHED_ERASE_EN
               cur       <= '{x0: x0, y0: y0, x1: x1, y1: y1};
               have_prev <= 1'b1;
`endif
            end
`ifdef DRAW_SCHED_ERASE_EN
            ERASE_GO: begin
               ld_line  <= cur;
               ld_color <= 1'b0;
               ld_start <= 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   assign {ld_x0, ld_y0, ld_x1, ld_y1} = ld_line;

   assign anim_step = (state == STEP);
   assign busy      = (state != IDLE) && (state != HOLD);

   frame_hold_timer #(
      .HOLD_FRAMES (HOLD_FRAMES)
   ) u_hold_timer (
      .clk        (clk),
      .reset      (reset),
      .clear      ((state == DRAW_WAIT) && line_done),
      .enable     (state == HOLD),
      .frame_tick (frame_tick),
      .done       (hold_done)
   );

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with HOLD_FRAMES=2; follows the erase
// build when DRAW_SCHED_ERASE_EN is defined.
module tb_draw_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
   logic        frame_tick = 1'b0;
   logic        ld_done = 1'b0;
   logic        ld_start;
   logic [10:0] ld_x0, ld_y0, ld_x1, ld_y1;
   logic        ld_color;
   logic        anim_step;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;
   int erase_starts = 0;

   draw_scheduler #(.HOLD_FRAMES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .x0         (x0),
      .y0         (y0),
      .x1         (x1),
      .y1         (y1),
      .frame_tick (frame_tick),
      .ld_done    (ld_done),
      .ld_start   (ld_start),
      .ld_x0      (ld_x0),
      .ld_y0      (ld_y0),
      .ld_x1      (ld_x1),
      .ld_y1      (ld_y1),
      .ld_color   (ld_color),
      .anim_step  (anim_step),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (ld_start && !ld_color) erase_starts++;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (ld_start) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse_done();
      ld_done = 1'b1;
      cycle();
      ld_done = 1'b0;
   endtask

   task automatic pulse_tick();
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) cycle();
      vectors++;
      if ({ld_start, anim_step, ld_color, busy} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b expected 0000", {ld_start, anim_step, ld_color, busy});
      end
      vectors++;
      if ({ld_x0, ld_y0, ld_x1, ld_y1} !== 44'd0) begin
         miscompares++;
         $display("FAIL reset_coords: got %h expected 0", {ld_x0, ld_y0, ld_x1, ld_y1});
      end
   endtask

   task automatic test_first_draw();
      bit seen;
      x0 = 11'd0; y0 = 11'd0; x1 = 11'd639; y1 = 11'd479;
      reset = 1'b0;
      wait_start(seen);
      vectors++;
      if (!seen || ld_color !== 1'b1) begin
         miscompares++;
         $display("FAIL first_start: seen %0d color %b expected seen 1 color 1", seen, ld_color);
      end
      vectors++;
      if ({ld_x0, ld_y0, ld_x1, ld_y1} !== {11'd0, 11'd0, 11'd639, 11'd479}) begin
         miscompares++;
         $display("FAIL first_coords: got %0d,%0d,%0d,%0d expected 0,0,639,479", ld_x0, ld_y0, ld_x1, ld_y1);
      end
      // done coinciding with ld_start and a frame tick mid-wait must not end the line
      ld_done = 1'b1;
      cycle();
      ld_done = 1'b0;
      vectors++;
      if ({ld_start, busy} !== 2'b01) begin
         miscompares++;
         $display("FAIL start_pulse_early_done: got start/busy %b expected 01", {ld_start, busy});
      end
      x0 = 11'd5;
      pulse_tick();
      repeat (2) cycle();
      vectors++;
      if (busy !== 1'b1 || ld_x0 !== 11'd0) begin
         miscompares++;
         $display("FAIL wait_ignore: got busy %b ld_x0 %0d expected busy 1 ld_x0 0", busy, ld_x0);
      end
      cycle();
      pulse_done();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL enter_hold: got busy %b expected 0", busy);
      end
   endtask

   task automatic test_hold();
      pulse_tick();
      vectors++;
      if ({anim_step, busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL one_tick: got step/busy %b expected 00", {anim_step, busy});
      end
      pulse_done();
      x0 = 11'd1; y0 = 11'd0; x1 = 11'd638; y1 = 11'd479;
      repeat (3) cycle();
      vectors++;
      if ({anim_step, busy} !== 2'b00 || ld_x1 !== 11'd639) begin
         miscompares++;
         $display("FAIL hold_ignore: got step/busy %b ld_x1 %0d expected 00 639", {anim_step, busy}, ld_x1);
      end
      pulse_tick();
      vectors++;
      if ({anim_step, busy} !== 2'b11) begin
         miscompares++;
         $display("FAIL second_tick_step: got step/busy %b expected 11", {anim_step, busy});
      end
      cycle();
      vectors++;
      if ({anim_step, busy} !== 2'b01) begin
         miscompares++;
         $display("FAIL step_single: got step/busy %b expected 01", {anim_step, busy});
      end
   endtask

   task automatic test_next_line();
      bit seen;
`ifdef DRAW_SCHED_ERASE_EN
      wait_start(seen);
      vectors++;
      if (!seen || ld_color !== 1'b0 ||
          {ld_x0, ld_y0, ld_x1, ld_y1} !== {11'd0, 11'd0, 11'd639, 11'd479}) begin
         miscompares++;
         $display("FAIL erase_start: seen %0d color %b coords %0d,%0d,%0d,%0d expected 1 0 0,0,639,479",
                  seen, ld_color, ld_x0, ld_y0, ld_x1, ld_y1);
      end
      cycle();
      pulse_done();
`endif
      wait_start(seen);
      vectors++;
      if (!seen || ld_color !== 1'b1 ||
          {ld_x0, ld_y0, ld_x1, ld_y1} !== {11'd1, 11'd0, 11'd638, 11'd479}) begin
         miscompares++;
         $display("FAIL next_draw: seen %0d color %b coords %0d,%0d,%0d,%0d expected 1 1 1,0,638,479",
                  seen, ld_color, ld_x0, ld_y0, ld_x1, ld_y1);
      end
      cycle();
      pulse_done();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL next_hold: got busy %b expected 0", busy);
      end
   endtask

   task automatic test_reset_mid_line();
      bit seen;
      pulse_tick();
      pulse_tick();
`ifdef DRAW_SCHED_ERASE_EN
      wait_start(seen);
      cycle();
      pulse_done();
`endif
      wait_start(seen);
      cycle();
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if ({ld_start, anim_step, ld_color, busy} !== 4'b0000 ||
          {ld_x0, ld_y0, ld_x1, ld_y1} !== 44'd0) begin
         miscompares++;
         $display("FAIL async_reset: got ctrl %b coords %h expected 0000 0",
                  {ld_start, anim_step, ld_color, busy}, {ld_x0, ld_y0, ld_x1, ld_y1});
      end
      cycle();
      reset = 1'b0;
      x0 = 11'd7; y0 = 11'd8; x1 = 11'd9; y1 = 11'd10;
      wait_start(seen);
      vectors++;
      if (!seen || ld_color !== 1'b1 ||
          {ld_x0, ld_y0, ld_x1, ld_y1} !== {11'd7, 11'd8, 11'd9, 11'd10}) begin
         miscompares++;
         $display("FAIL post_reset_draw: seen %0d color %b coords %0d,%0d,%0d,%0d expected 1 1 7,8,9,10",
                  seen, ld_color, ld_x0, ld_y0, ld_x1, ld_y1);
      end
      cycle();
      pulse_done();
   endtask

   initial begin
      int exp_erases;
      test_reset();
      test_first_draw();
      test_hold();
      test_next_line();
      test_reset_mid_line();
`ifdef DRAW_SCHED_ERASE_EN
      exp_erases = 2;
`else
      exp_erases = 0;
`endif
      vectors++;
      if (erase_starts !== exp_erases) begin
         miscompares++;
         $display("FAIL erase_count: got %0d expected %0d", erase_starts, exp_erases);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
